// File: rtl/mem_stage_ws_if.sv
// Execute -> MEM -> write-back bus for mem_stage_ws.
// The master drives the EX/MEM controls and samples the stall and MEM/WB outputs.
// The slave is the MEM stage itself.
interface mem_stage_ws_if;
  logic        xm_memtoreg;
  logic        xm_regwrite;
  logic        xm_memread;
  logic        xm_memwrite;
  logic [1:0]  xm_size;
  logic        xm_unsigned;
  logic [31:0] alu_out;
  logic [4:0]  xm_rd;
  logic [31:0] xm_md;
  logic        mem_stall;
  logic        mw_memtoreg;
  logic        mw_regwrite;
  logic [31:0] mw_aluout;
  logic [31:0] mdr;
  logic [4:0]  mw_rd;
  logic        mw_misalign;

  modport master (
    output xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_size,
           xm_unsigned, alu_out, xm_rd, xm_md,
    input  mem_stall, mw_memtoreg, mw_regwrite, mw_aluout, mdr, mw_rd,
           mw_misalign
  );

  modport slave (
    input  xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite, xm_size,
           xm_unsigned, alu_out, xm_rd, xm_md,
    output mem_stall, mw_memtoreg, mw_regwrite, mw_aluout, mdr, mw_rd,
           mw_misalign
  );
endinterface

// File: rtl/mem_stage_ws.sv
// mem_stage_ws: EX/MEM -> MEM/WB boundary with an internal byte-addressed
// data memory, configurable wait states (stall upstream) and misalignment
// detection. Define MEM_STATS_EN to add saturating load/store/stall counters.
module mem_stage_ws #(
  parameter int          ADDR_W     = 7,
  parameter int          WAIT_CYC   = 2,
  parameter logic [31:0] INIT_WORD0 = 32'd10
) (
  input  logic               clk,
  input  logic               rst,
  mem_stage_ws_if.slave      bus
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]        stat_rd,
  output logic [15:0]        stat_wr,
  output logic [15:0]        stat_stall
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                mw_memtoreg_q, mw_memtoreg_d;
  logic                mw_regwrite_q, mw_regwrite_d;
  logic [31:0]         mw_aluout_q, mw_aluout_d;
  logic [31:0]         mdr_q, mdr_d;
  logic [4:0]          mw_rd_q, mw_rd_d;
  logic                mw_misalign_q, mw_misalign_d;
  logic [31:0]         mem_q [DEPTH];

  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          lane;
  logic [31:0]         rd_word;
  logic                access, misalign, aligned_acc, is_ld, is_st;
  logic                stall_c, mem_we;
  logic [31:0]         mem_wdata;

  // Store merge: replace only the addressed byte lanes of the old word.
  function automatic logic [31:0] merge_store(input logic [31:0] old_w,
                                              input logic [31:0] md,
                                              input logic [1:0]  size,
                                              input logic [1:0]  ln);
    logic [31:0] w;
    w = old_w;
    case (size)
      2'b00: w[8*ln +: 8] = md[7:0];
      2'b01: w[16*ln[1] +: 16] = md[15:0];
      default: w = md;
    endcase
    return w;
  endfunction

  // Load extraction: select lane, then sign- or zero-extend byte/half.
  function automatic logic [31:0] extend_load(input logic [31:0] w,
                                              input logic [1:0]  size,
                                              input logic [1:0]  ln,
                                              input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = $signed(w[8*ln +: 8]);
    h = $signed(w[16*ln[1] +: 16]);
    case (size)
      2'b00:   r = uns ? $signed({24'd0, b}) : 32'(b);
      2'b01:   r = uns ? $signed({16'd0, h}) : 32'(h);
      default: r = $signed(w);
    endcase
    return r;
  endfunction

  // Address decode, misalignment and stall generation.
  always_comb begin
    word_idx    = bus.alu_out[ADDR_W+1:2];
    lane        = bus.alu_out[1:0];
    rd_word     = mem_q[word_idx];
    access      = bus.xm_memread | bus.xm_memwrite;
    misalign    = access &
                  (((bus.xm_size == 2'b01) & bus.alu_out[0]) |
                   (bus.xm_size[1] & (bus.alu_out[1:0] != 2'b00)));
    aligned_acc = access & ~misalign;
    is_st       = aligned_acc & bus.xm_memwrite;
    is_ld       = aligned_acc & bus.xm_memread & ~bus.xm_memwrite;
    stall_c     = 1'b0;
    if (state_q == S_IDLE)
      stall_c = aligned_acc & (WAIT_CYC != 0);
    else
      stall_c = (cnt_q != 4'd0);
    mem_we      = is_st & ~stall_c;
    mem_wdata   = merge_store(rd_word, bus.xm_md, bus.xm_size, lane);
  end

  // Next-state for the wait FSM and the MEM/WB register bank.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mw_memtoreg_d = mw_memtoreg_q;
    mw_regwrite_d = mw_regwrite_q;
    mw_aluout_d   = mw_aluout_q;
    mdr_d         = mdr_q;
    mw_rd_d       = mw_rd_q;
    mw_misalign_d = mw_misalign_q;
    if (stall_c) begin
      // Bubble into write-back while the memory is busy.
      mw_memtoreg_d = 1'b0;
      mw_regwrite_d = 1'b0;
      mw_misalign_d = 1'b0;
      if (state_q == S_IDLE) begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_CYC - 1);
      end else begin
        cnt_d   = cnt_q - 4'd1;
      end
    end else begin
      state_d       = S_IDLE;
      cnt_d         = 4'd0;
      mw_memtoreg_d = bus.xm_memtoreg;
      mw_regwrite_d = bus.xm_regwrite & ~misalign;
      mw_aluout_d   = bus.alu_out;
      mw_rd_d       = bus.xm_rd;
      mw_misalign_d = misalign;
      if (is_ld)
        mdr_d = extend_load(rd_word, bus.xm_size, lane, bus.xm_unsigned);
    end
  end

  // FSM and MEM/WB registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      mw_memtoreg_q <= 1'b0;
      mw_regwrite_q <= 1'b0;
      mw_aluout_q   <= '0;
      mdr_q         <= '0;
      mw_rd_q       <= '0;
      mw_misalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mw_memtoreg_q <= mw_memtoreg_d;
      mw_regwrite_q <= mw_regwrite_d;
      mw_aluout_q   <= mw_aluout_d;
      mdr_q         <= mdr_d;
      mw_rd_q       <= mw_rd_d;
      mw_misalign_q <= mw_misalign_d;
    end
  end

  // Data memory: cleared on reset with word 0 preloaded; store commits at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= (i == 0) ? INIT_WORD0 : 32'd0;
    end else if (mem_we) begin
      mem_q[word_idx] <= mem_wdata;
    end
  end

  assign bus.mem_stall   = stall_c & ~rst;
  assign bus.mw_memtoreg = mw_memtoreg_q;
  assign bus.mw_regwrite = mw_regwrite_q;
  assign bus.mw_aluout   = mw_aluout_q;
  assign bus.mdr         = mdr_q;
  assign bus.mw_rd       = mw_rd_q;
  assign bus.mw_misalign = mw_misalign_q;

`ifdef MEM_STATS_EN
  logic [15:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_wr_q, stat_wr_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  // Saturating activity counters.
  always_comb begin
    stat_rd_d    = sat_inc(stat_rd_q, is_ld & ~stall_c);
    stat_wr_d    = sat_inc(stat_wr_q, is_st & ~stall_c);
    stat_stall_d = sat_inc(stat_stall_q, stall_c);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_rd_q    <= stat_rd_d;
      stat_wr_q    <= stat_wr_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_rd    = stat_rd_q;
  assign stat_wr    = stat_wr_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_mem_stage_ws.sv
// Bench for mem_stage_ws: scoreboard-checked directed vectors on a
// WAIT_CYC=2 instance, plus a WAIT_CYC=0 instance for single-cycle behaviour.
module tb_mem_stage_ws;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_ws_if ba ();
  mem_stage_ws_if bz ();

`ifdef MEM_STATS_EN
  logic [15:0] a_rd, a_wr, a_st, z_rd, z_wr, z_st;
`endif

  mem_stage_ws #(.ADDR_W(7), .WAIT_CYC(2), .INIT_WORD0(32'd10)) u_dut (
    .clk(clk), .rst(rst), .bus(ba.slave)
`ifdef MEM_STATS_EN
    , .stat_rd(a_rd), .stat_wr(a_wr), .stat_stall(a_st)
`endif
  );

  mem_stage_ws #(.ADDR_W(7), .WAIT_CYC(0), .INIT_WORD0(32'd10)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bz.slave)
`ifdef MEM_STATS_EN
    , .stat_rd(z_rd), .stat_wr(z_wr), .stat_stall(z_st)
`endif
  );

  typedef struct packed {
    logic        memtoreg;
    logic        regwrite;
    logic [31:0] alu;
    logic [31:0] mdr;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic active  = 1'b0;
  logic pend    = 1'b0;
  logic bub     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops the expected MEM/WB contents after each completion edge
  // and checks that every stalled edge produced a bubble.
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("mw_memtoreg", {31'd0, ba.mw_memtoreg}, {31'd0, e.memtoreg});
        chk("mw_regwrite", {31'd0, ba.mw_regwrite}, {31'd0, e.regwrite});
        chk("mw_aluout", ba.mw_aluout, e.alu);
        chk("mdr", ba.mdr, e.mdr);
        chk("mw_rd", {27'd0, ba.mw_rd}, {27'd0, e.rd});
        chk("mw_misalign", {31'd0, ba.mw_misalign}, {31'd0, e.mis});
      end
    end
    if (bub) begin
      chk("bubble_regwrite", {31'd0, ba.mw_regwrite}, 32'd0);
      chk("bubble_misalign", {31'd0, ba.mw_misalign}, 32'd0);
    end
    pend = active & ~ba.mem_stall;
    bub  = active & ba.mem_stall;
  end

  task automatic idle_a();
    ba.xm_memtoreg = 0; ba.xm_regwrite = 0; ba.xm_memread = 0; ba.xm_memwrite = 0;
    ba.xm_size = 2'b10; ba.xm_unsigned = 0; ba.alu_out = 0; ba.xm_rd = 0; ba.xm_md = 0;
  endtask

  task automatic idle_z();
    bz.xm_memtoreg = 0; bz.xm_regwrite = 0; bz.xm_memread = 0; bz.xm_memwrite = 0;
    bz.xm_size = 2'b10; bz.xm_unsigned = 0; bz.alu_out = 0; bz.xm_rd = 0; bz.xm_md = 0;
  endtask

  // Driver: presents one transaction (called #1 after a posedge), holds it
  // while stalled and pushes the hand-computed MEM/WB result.
  task automatic issue(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] md,
                       input logic [4:0] rd, input logic rw, input logic m2r,
                       input logic [31:0] exp_mdr, input logic mis, input int exp_st);
    exp_t e;
    int   st;
    ba.xm_memread = rd_en; ba.xm_memwrite = wr_en; ba.xm_size = sz;
    ba.xm_unsigned = uns; ba.alu_out = addr; ba.xm_md = md; ba.xm_rd = rd;
    ba.xm_regwrite = rw; ba.xm_memtoreg = m2r;
    e.memtoreg = m2r; e.regwrite = rw & ~mis; e.alu = addr; e.mdr = exp_mdr;
    e.rd = rd; e.mis = mis;
    exp_q.push_back(e);
    active = 1'b1;
    st = 0;
    forever begin
      @(negedge clk);
      if (!ba.mem_stall) break;
      st++;
      if (st > 40) break;
    end
    chk("stall_cycles", st, exp_st);
    @(posedge clk);
    #1;
    active = 1'b0;
    idle_a();
  endtask

  initial begin
    idle_a();
    idle_z();
    #12;
    chk("rst_stall", {31'd0, ba.mem_stall}, 32'd0);
    chk("rst_mdr", ba.mdr, 32'd0);
    chk("rst_regwrite", {31'd0, ba.mw_regwrite}, 32'd0);
    chk("rst_aluout", ba.mw_aluout, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(1,0,2'b10,0,32'd0,        32'd0,          5'd1, 1,1, 32'h0000000A, 0, 2);
    issue(0,1,2'b10,0,32'd8,        32'hDEADBEEF,   5'd0, 0,0, 32'h0000000A, 0, 2);
    issue(1,0,2'b00,1,32'd9,        32'd0,          5'd2, 1,1, 32'h000000BE, 0, 2);
    issue(1,0,2'b01,0,32'd10,       32'd0,          5'd3, 1,1, 32'hFFFFDEAD, 0, 2);
    issue(0,1,2'b10,0,32'd12,       32'h11223344,   5'd0, 0,0, 32'hFFFFDEAD, 0, 2);
    issue(0,1,2'b00,0,32'd13,       32'hFFFFFF5A,   5'd0, 0,0, 32'hFFFFDEAD, 0, 2);
    issue(1,0,2'b10,0,32'd12,       32'd0,          5'd4, 1,1, 32'h11225A44, 0, 2);
    issue(1,0,2'b01,0,32'd3,        32'd0,          5'd5, 1,1, 32'h11225A44, 1, 0);
    issue(0,1,2'b10,0,32'd6,        32'hFFFFFFFF,   5'd0, 0,0, 32'h11225A44, 1, 0);
    issue(1,0,2'b10,0,32'd4,        32'd0,          5'd6, 1,1, 32'h00000000, 0, 2);
    issue(0,0,2'b10,0,32'h12345678, 32'd0,          5'd7, 1,0, 32'h00000000, 0, 0);
    issue(1,0,2'b00,0,32'd11,       32'd0,          5'd8, 1,1, 32'hFFFFFFDE, 0, 2);
    issue(1,0,2'b01,1,32'd10,       32'd0,          5'd9, 1,1, 32'h0000DEAD, 0, 2);
    issue(1,1,2'b10,0,32'd20,       32'hCAFEF00D,   5'd0, 1,0, 32'h0000DEAD, 0, 2);
    issue(1,0,2'b10,0,32'd532,      32'd0,          5'd10,1,1, 32'hCAFEF00D, 0, 2);
    issue(0,1,2'b01,0,32'd14,       32'h0000BEEF,   5'd0, 0,0, 32'hCAFEF00D, 0, 2);
    issue(1,0,2'b10,0,32'd12,       32'd0,          5'd11,1,1, 32'hBEEF5A44, 0, 2);

    // Reset in the middle of a stalled store to address 16.
    ba.xm_memwrite = 1; ba.xm_size = 2'b10; ba.alu_out = 32'd16; ba.xm_md = 32'h55AA55AA;
    @(negedge clk);
    chk("wait_stall_before_rst", {31'd0, ba.mem_stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, ba.mem_stall}, 32'd0);
    chk("rst_mid_mdr", ba.mdr, 32'd0);
    chk("rst_mid_rd", {27'd0, ba.mw_rd}, 32'd0);
    idle_a();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_stall", {31'd0, ba.mem_stall}, 32'd0);
    @(posedge clk); #1;
    issue(1,0,2'b10,0,32'd16, 32'd0, 5'd12, 1,1, 32'h00000000, 0, 2);
    issue(1,0,2'b10,0,32'd0,  32'd0, 5'd13, 1,1, 32'h0000000A, 0, 2);
    issue(1,0,2'b10,0,32'd8,  32'd0, 5'd14, 1,1, 32'h00000000, 0, 2);
    repeat (3) @(posedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
`ifdef MEM_STATS_EN
    chk("a_stat_rd", {16'd0, a_rd}, 32'd3);
    chk("a_stat_wr", {16'd0, a_wr}, 32'd0);
    chk("a_stat_stall", {16'd0, a_st}, 32'd6);
`endif

    // Single-cycle instance: load, store, load on consecutive cycles.
    #1;
    bz.xm_memread = 1; bz.alu_out = 32'd0; bz.xm_rd = 5'd1; bz.xm_regwrite = 1; bz.xm_memtoreg = 1;
    @(negedge clk);
    chk("z_stall_ld0", {31'd0, bz.mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("z_mdr_ld0", bz.mdr, 32'h0000000A);
    chk("z_regwrite_ld0", {31'd0, bz.mw_regwrite}, 32'd1);
    bz.xm_memread = 0; bz.xm_memwrite = 1; bz.alu_out = 32'd4; bz.xm_md = 32'h00000077;
    bz.xm_rd = 5'd0; bz.xm_regwrite = 0; bz.xm_memtoreg = 0;
    @(negedge clk);
    chk("z_stall_st", {31'd0, bz.mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("z_aluout_st", bz.mw_aluout, 32'd4);
    chk("z_mdr_hold_st", bz.mdr, 32'h0000000A);
    bz.xm_memwrite = 0; bz.xm_memread = 1; bz.xm_rd = 5'd2; bz.xm_regwrite = 1; bz.xm_memtoreg = 1;
    @(negedge clk);
    chk("z_stall_ld4", {31'd0, bz.mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("z_mdr_ld4", bz.mdr, 32'h00000077);
    chk("z_rd_ld4", {27'd0, bz.mw_rd}, 32'd2);
    idle_z();
    @(posedge clk); #1;
`ifdef MEM_STATS_EN
    chk("z_stat_rd", {16'd0, z_rd}, 32'd2);
    chk("z_stat_wr", {16'd0, z_wr}, 32'd1);
    chk("z_stat_stall", {16'd0, z_st}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_stage_ws.md
Name: mem_stage_ws

Overview:
Parametrised successor to the pipeline MEM stage. It is the EX/MEM → MEM/WB boundary with an internal data memory, and adds:
- byte-addressed byte/halfword/word loads and stores, with sign or zero extension on loads;
- configurable memory wait states, signalled upstream with a stall;
- misalignment detection.
It sits between the execute stage and write-back, and drives the hazard unit's stall input.

Parameters:
ADDR_W, 7, word-index bits; memory depth = 2**ADDR_W 32-bit words.
WAIT_CYC, 2, wait states per aligned memory access (0..15); 0 = single-cycle memory.
INIT_WORD0, 10, value loaded into word 0 on reset.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
xm_memtoreg  in  1  write-back selects memory data
xm_regwrite  in  1  register-file write enable
xm_memread  in  1  load request
xm_memwrite  in  1  store request
xm_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
xm_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
alu_out  in  32  byte address / ALU result
xm_rd  in  5  destination register
xm_md  in  32  store data (low bits used for byte/half)
mem_stall  out  1  combinational; upstream must hold all xm_* inputs stable while high
mw_memtoreg  out  1  registered
mw_regwrite  out  1  registered
mw_aluout  out  32  registered
mdr  out  32  registered load data, already extended
mw_rd  out  5  registered
mw_misalign  out  1  registered one-cycle misalignment flag

Behaviour:
- Access = xm_memread | xm_memwrite. If both are set, the write is performed and the read is ignored; mdr holds.
- Word index = alu_out[ADDR_W+1:2]. Byte lane = alu_out[1:0]. Upper address bits are ignored (wrap-around).
- Misaligned access:
  - half with alu_out[0]=1, or word with alu_out[1:0]≠0;
  - takes no wait states and writes nothing;
  - mdr holds its previous value;
  - next edge: mw_regwrite=0, mw_misalign=1.
- FSM states: IDLE, WAIT. 4-bit counter cnt.
  - IDLE, aligned access, WAIT_CYC>0: mem_stall=1. Edge: state←WAIT, cnt←WAIT_CYC-1, MW registers load a bubble (mw_regwrite=0, mw_memtoreg=0, mw_misalign=0; mw_rd, mw_aluout, mdr hold).
  - WAIT, cnt≠0: mem_stall=1. Edge: cnt←cnt-1, bubble again.
  - WAIT, cnt=0: mem_stall=0 (completion cycle). Edge: access performed, MW registers load normally, state←IDLE.
  - IDLE, no access / misaligned / WAIT_CYC=0: mem_stall=0, one-cycle pass-through.
- Stall length: exactly WAIT_CYC stalled cycles per aligned access. Total latency from first presentation to MW update = WAIT_CYC+1 edges.
- Back-to-back accesses each incur the full wait.
- A store commits exactly once, at the completion edge, to the addressed byte lanes only. Other bytes of the word are unchanged.
- Load data: byte/half selected by lane, then extended per xm_unsigned to 32 bits. Word loads are not extended.
- Non-load pass-through (including completed stores): mdr holds; mw_aluout←alu_out; mw_rd←xm_rd; control bits copied; mw_misalign←0.
- Reset (any time, including mid-WAIT):
  - state=IDLE, cnt=0;
  - all memory words = 0, then word 0 = INIT_WORD0;
  - all outputs 0, mem_stall=0;
  - a pending store is discarded.

Optional Feature:
Macro MEM_STATS_EN.
- Defined: adds output ports stat_rd[15:0], stat_wr[15:0], stat_stall[15:0], with saturating counters at 16'hFFFF:
  - stat_rd increments on completed aligned loads;
  - stat_wr increments on completed aligned stores;
  - stat_stall increments on every cycle with mem_stall=1;
  - all cleared by rst.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then word load, WAIT_CYC=2, addr 0 -> mem_stall high 2 cycles, then mdr=10, mw_regwrite=1 after the 3rd edge.
- Store word 0xDEADBEEF to addr 8, then byte load unsigned addr 9 -> mdr=0x000000BE; signed half load addr 10 -> mdr=0xFFFFDEAD.
- Store byte 0x5A to addr 13 over a prior word 0x11223344 at addr 12 -> word load from addr 12 reads 0x11225A44.
- Half load at addr 3 -> mem_stall stays 0; next edge mw_misalign=1, mw_regwrite=0, mdr unchanged; a word store at addr 6 leaves memory unchanged.
- Assert rst during WAIT of a store to addr 16 -> stall drops immediately, FSM is IDLE, and a word load of addr 16 after reset returns 0.
- WAIT_CYC=0 build: load then store then load on consecutive cycles -> mem_stall never asserted, each MW update one edge later; with MEM_STATS_EN, stat_rd=2, stat_wr=1, stat_stall=0.
